// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU with valid/ready handshake on both sides.
// Define ALU_FAST_SHIFT_EN for a single-cycle barrel shifter instead of the 1-bit/cycle iterative shifter.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       Operation,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             Illegal
);
  localparam int SHAMT_W = $clog2(WIDTH);
  localparam logic [3:0] OP_SLL = 4'b1001, OP_SRL = 4'b1100, OP_SRA = 4'b0111;
`ifdef ALU_FAST_SHIFT_EN
  typedef enum logic [1:0] {IDLE, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif
  state_t state, nxt;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0] res, fin;
  logic ill, fin_ill, accept, load;
  assign shamt = SrcB[SHAMT_W-1:0];
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign accept = in_valid && in_ready;
  always_comb begin
    res = '0;
    ill = 1'b0;
    case (Operation)
      4'b0000: res = SrcA & SrcB;
      4'b0001: res = SrcA ^ SrcB;
      4'b0011: res = SrcA | SrcB;
      4'b0010: res = SrcA + SrcB;
      4'b0110: res = SrcA - SrcB;
`ifdef ALU_FAST_SHIFT_EN
      OP_SLL: res = SrcA << shamt;
      OP_SRL: res = SrcA >> shamt;
      OP_SRA: res = $signed(SrcA) >>> shamt;
`else
      // iterative build only completes a shift here when shamt is zero
      OP_SLL, OP_SRL, OP_SRA: res = SrcA;
`endif
      4'b1110: res = WIDTH'($signed(SrcA) < $signed(SrcB));
      4'b1111: res = WIDTH'(SrcA < SrcB);
      4'b1000: res = WIDTH'(SrcA == SrcB);
      4'b1010: res = SrcB;
      default: ill = 1'b1;
    endcase
  end
`ifdef ALU_FAST_SHIFT_EN
  assign load = accept;
  assign fin = res;
  assign fin_ill = ill;
`else
  logic [SHAMT_W-1:0] cnt;
  logic [WIDTH-1:0] shreg, shn;
  logic [3:0] sop;
  logic is_shift, last;
  assign is_shift = Operation == OP_SLL || Operation == OP_SRL || Operation == OP_SRA;
  assign last = state == SHIFT && cnt == SHAMT_W'(1);
  assign shn = sop == OP_SLL ? {shreg[WIDTH-2:0], 1'b0} : {sop == OP_SRA && shreg[WIDTH-1], shreg[WIDTH-1:1]};
  assign load = (accept && nxt == DONE) || last;
  assign fin = state == SHIFT ? shn : res;
  assign fin_ill = state == SHIFT ? 1'b0 : ill;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      shreg <= '0;
      sop <= '0;
    end else if (accept) begin
      cnt <= shamt;
      shreg <= SrcA;
      sop <= Operation;
    end else if (state == SHIFT) begin
      cnt <= cnt - SHAMT_W'(1);
      shreg <= shn;
    end
`endif
  always_comb begin
    nxt = state;
    case (state)
`ifdef ALU_FAST_SHIFT_EN
      IDLE: nxt = in_valid ? DONE : IDLE;
`else
      IDLE: nxt = !in_valid ? IDLE : (is_shift && shamt != '0) ? SHIFT : DONE;
      SHIFT: nxt = last ? DONE : SHIFT;
`endif
      DONE: nxt = out_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ALUResult <= '0;
      Zero <= 1'b0;
      Illegal <= 1'b0;
    end else begin
      state <= nxt;
      if (load) begin
        ALUResult <= fin;
        Zero <= fin == '0;
        Illegal <= fin_ill;
      end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed scoreboard bench for alu_exec_unit (latency expectations follow ALU_FAST_SHIFT_EN).
module tb_alu_exec_unit;
  localparam int W = 32;
`ifdef ALU_FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, Zero, Illegal;
  logic [3:0] Operation = '0;
  logic [W-1:0] SrcA = '0, SrcB = '0, ALUResult;
  int total = 0, bad = 0;
  typedef struct {string tag; logic [W-1:0] res; logic ill; int lat;} exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  alu_exec_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .Operation(Operation), .SrcA(SrcA), .SrcB(SrcB), .out_valid(out_valid),
    .out_ready(out_ready), .ALUResult(ALUResult), .Zero(Zero), .Illegal(Illegal)
  );
  function automatic int sl(input int s);
    return FAST ? 1 : s + 1;
  endfunction
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic send(input string tag, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] res, input logic ill, input int lat, input bit keep);
    @(negedge clk);
    check({tag, " in_ready"}, W'(in_ready), W'(1));
    Operation = op;
    SrcA = a;
    SrcB = b;
    in_valid = 1'b1;
    @(posedge clk);
    if (keep) sb.push_back('{tag, res, ill, lat});
    #1;
    in_valid = 1'b0;
    Operation = 4'b0101;
    SrcA = ~a;
    SrcB = ~b;
  endtask
  task automatic recv();
    exp_t e = sb.pop_front();
    int lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({e.tag, " latency"}, W'(lat), W'(e.lat));
    check({e.tag, " result"}, ALUResult, e.res);
    check({e.tag, " zero"}, W'(Zero), W'(e.res == '0));
    check({e.tag, " illegal"}, W'(Illegal), W'(e.ill));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({e.tag, " valid_drop"}, W'(out_valid), W'(0));
  endtask
  task automatic op(input string tag, input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic [W-1:0] res, input logic ill, input int lat);
    send(tag, o, a, b, res, ill, lat, 1'b1);
    recv();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bit seen;
    repeat (2) @(negedge clk);
    check("reset out_valid", W'(out_valid), W'(0));
    check("reset result", ALUResult, '0);
    check("reset zero", W'(Zero), W'(0));
    check("reset illegal", W'(Illegal), W'(0));
    check("reset in_ready", W'(in_ready), W'(1));
    rst_n = 1'b1;
    op("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1);
    op("sub_neg", 4'b0110, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1);
    op("sub_zero", 4'b0110, 32'd9, 32'd9, 32'h0, 1'b0, 1);
    op("and", 4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1);
    op("xor", 4'b0001, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFF00_ED34, 1'b0, 1);
    op("or", 4'b0011, 32'hF0F0_1234, 32'h0FF0_FF00, 32'hFFF0_FF34, 1'b0, 1);
    op("sra31", 4'b0111, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, sl(31));
    op("srl31", 4'b1100, 32'h8000_0000, 32'd31, 32'h0000_0001, 1'b0, sl(31));
    op("sll0", 4'b1001, 32'h1, 32'd0, 32'h1, 1'b0, 1);
    op("sll_hi_b", 4'b1001, 32'h3, 32'h21, 32'h6, 1'b0, sl(1));
    op("sra_pos", 4'b0111, 32'h4000_0000, 32'd3, 32'h0800_0000, 1'b0, sl(3));
    op("srl4", 4'b1100, 32'hF000_0000, 32'd4, 32'h0F00_0000, 1'b0, sl(4));
    op("slt", 4'b1110, 32'hFFFF_FFFF, 32'd1, 32'h1, 1'b0, 1);
    op("sltu", 4'b1111, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b0, 1);
    op("slt_rev", 4'b1110, 32'd1, 32'hFFFF_FFFF, 32'h0, 1'b0, 1);
    op("sltu_rev", 4'b1111, 32'd1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1);
    op("eq_true", 4'b1000, 32'd3, 32'd3, 32'h1, 1'b0, 1);
    op("eq_false", 4'b1000, 32'd3, 32'd4, 32'h0, 1'b0, 1);
    op("pass_b", 4'b1010, 32'hDEAD_BEEF, 32'h1234_5000, 32'h1234_5000, 1'b0, 1);
    op("illegal", 4'b0101, 32'hFFFF, 32'hFFFF, 32'h0, 1'b1, 1);
    op("illegal4", 4'b0100, 32'h1, 32'h2, 32'h0, 1'b1, 1);
    op("after_ill", 4'b0010, 32'd2, 32'd2, 32'd4, 1'b0, 1);
    send("bp_or", 4'b0011, 32'hF0F0_1234, 32'h0FF0_FF00, '0, 1'b0, 0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp out_valid", W'(out_valid), W'(1));
      check("bp hold", ALUResult, 32'hFFF0_FF34);
      check("bp in_ready", W'(in_ready), W'(0));
      in_valid = i[0];
      Operation = 4'b0010;
      SrcA = 32'd1;
      SrcB = 32'd1;
    end
    in_valid = 1'b0;
    sb.push_back('{"bp_or", 32'hFFF0_FF34, 1'b0, 1});
    recv();
    op("bp_next", 4'b0110, 32'd100, 32'd1, 32'd99, 1'b0, 1);
    send("rst_sll20", 4'b1001, 32'h1, 32'd20, '0, 1'b0, 0, 1'b0);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst out_valid", W'(out_valid), W'(0));
    check("midrst result", ALUResult, '0);
    check("midrst zero", W'(Zero), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      seen |= out_valid;
    end
    check("midrst stale", W'(seen), W'(0));
    op("post_rst", 4'b0010, 32'd10, 32'd20, 32'd30, 1'b0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
